// File: rtl/tff_pkg.sv
// Shared types and limits for the T flip-flop bank.
package tff_pkg;

    typedef enum logic [1:0] {
        TOGGLE = 2'd0,
        UP     = 2'd1,
        DOWN   = 2'd2,
        LOAD   = 2'd3
    } tff_mode_t;

    localparam int TFF_MAX_WIDTH = 32;

endpackage

// File: rtl/tff_cell.sv
// Single edge-triggered toggle cell with synchronous reset and parallel load.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic en,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= rst_val;
        end else if (en) begin
            if (ld) begin
                q <= d;
            end else if (t) begin
                q <= ~q;
            end
        end
    end

endmodule

// File: rtl/tff_bank.sv
// Bank of T cells usable as a toggle register, an up/down counter or a loadable register.
module tff_bank
    import tff_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter bit               SATURATE = 1'b0,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  tff_mode_t        mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic [WIDTH-1:0] toggled
);

    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] cell_t;
    logic [WIDTH-1:0] q_next;
    logic             ld;
    logic             boundary;

    // Ripple-style AND prefix; synthesis restructures it into a log-depth tree.
    always_comb begin
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] & q[i-1];
            dn_t[i] = dn_t[i-1] & ~q[i-1];
        end
    end

    always_comb begin
        cell_t   = '0;
        ld       = 1'b0;
        boundary = 1'b0;
        case (mode)
            TOGGLE: cell_t = t;
            UP: begin
                boundary = &q;
                cell_t   = (SATURATE && boundary) ? '0 : up_t;
            end
            DOWN: begin
                boundary = ~|q;
                cell_t   = (SATURATE && boundary) ? '0 : dn_t;
            end
            LOAD:    ld = 1'b1;
            default: cell_t = '0;
        endcase
        q_next = ld ? load_val : (q ^ cell_t);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RST_VAL[i]),
            .en      (en),
            .t       (cell_t[i]),
            .ld      (ld),
            .d       (load_val[i]),
            .q       (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tc      <= 1'b0;
            toggled <= '0;
        end else if (en) begin
            tc      <= boundary;
            toggled <= q_next ^ q;
        end else begin
            tc      <= 1'b0;
            toggled <= '0;
        end
    end

endmodule
